bcrypt_mem_arbiter: RTL and testbench

BCRYPT_MEM_ARBITER -- requirements
Module: bcrypt_mem_arbiter

---
 rtl/bcrypt_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_bcrypt_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcrypt_mem_arbiter.sv
// Two-requester burst arbiter in front of a single-port local memory (1-cycle read latency).
// Define BCRYPT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module bcrypt_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd0_valid,
    output logic              cmd0_ready,
    input  logic              cmd0_we,
    input  logic [ADDR_W-1:0] cmd0_addr,
    input  logic [2:0]        cmd0_len,
    input  logic              cmd1_valid,
    output logic              cmd1_ready,
    input  logic              cmd1_we,
    input  logic [ADDR_W-1:0] cmd1_addr,
    input  logic [2:0]        cmd1_len,
    input  logic [DATA_W-1:0] wd0_data,
    output logic              wd0_ready,
    input  logic [DATA_W-1:0] wd1_data,
    output logic              wd1_ready,
    output logic              rd0_valid,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done0,
    output logic              done1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        len_q;
    logic [2:0]        cnt;
    logic              rd_valid_q;
    logic              sel;
    logic              accept;
    logic              last_beat;
    logic              beat_active;
`ifndef BCRYPT_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    // Arbitration: a lone requester always wins; ties go to the fixed or rotating winner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel = cmd1_valid;
        if (cmd0_valid && cmd1_valid) begin
`ifdef BCRYPT_ARB_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel = ~last_grant;
`endif
        end
        accept     = (state == IDLE) && (cmd0_valid || cmd1_valid) && !ARESET;
        cmd0_ready = accept && !sel;
        cmd1_ready = accept && sel;
    end

    assign last_beat   = (cnt == len_q);
    assign beat_active = (state == WRITE) || (state == READ);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (sel ? cmd1_we : cmd0_we) ? WRITE : READ;
            WRITE:   if (last_beat) state_nxt = IDLE;
            READ:    if (last_beat) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (ARESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            rd_valid_q <= 1'b0;
`ifndef BCRYPT_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            rd_valid_q <= (state == READ);
            if (accept) begin
                owner  <= sel;
                addr_q <= sel ? cmd1_addr : cmd0_addr;
                len_q  <= sel ? cmd1_len : cmd0_len;
                cnt    <= '0;
`ifndef BCRYPT_ARB_FIXED_PRIO_EN
                last_grant <= sel;
`endif
            end else if (beat_active) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Data-path outputs are forced to zero outside their active phase so idle/reset reads as 0.
    assign mem_en    = beat_active;
    assign mem_we    = (state == WRITE);
    assign mem_addr  = beat_active ? addr_q + ADDR_W'(cnt) : '0;
    assign mem_wdata = (state == WRITE) ? (owner ? wd1_data : wd0_data) : '0;
    assign wd0_ready = (state == WRITE) && !owner;
    assign wd1_ready = (state == WRITE) && owner;
    assign rd0_valid = rd_valid_q && !owner;
    assign rd1_valid = rd_valid_q && owner;
    assign rd_data   = rd_valid_q ? mem_rdata : '0;
    assign done0     = !owner && (((state == WRITE) && last_beat) || (state == DRAIN));
    assign done1     = owner && (((state == WRITE) && last_beat) || (state == DRAIN));
    assign busy      = (state != IDLE);
    assign grant_id  = owner;

endmodule

// File: tb/tb_bcrypt_mem_arbiter.sv
// Directed self-checking bench for bcrypt_mem_arbiter with a behavioural 256-word memory.
module tb_bcrypt_mem_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd0_valid = 0, cmd1_valid = 0, cmd0_we = 0, cmd1_we = 0;
    logic [7:0]  cmd0_addr = 0, cmd1_addr = 0;
    logic [2:0]  cmd0_len = 0, cmd1_len = 0;
    logic [31:0] wd0_data = 0, wd1_data = 0;
    logic        cmd0_ready, cmd1_ready, wd0_ready, wd1_ready;
    logic        rd0_valid, rd1_valid, done0, done1;
    logic        mem_en, mem_we, busy, grant_id;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, rd_data;
    logic [31:0] mem_rdata = 0;
    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail = 0;
    logic exp_g;
    logic [31:0] wrap_data [4];

    bcrypt_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd0_valid(cmd0_valid), .cmd0_ready(cmd0_ready), .cmd0_we(cmd0_we),
        .cmd0_addr(cmd0_addr), .cmd0_len(cmd0_len),
        .cmd1_valid(cmd1_valid), .cmd1_ready(cmd1_ready), .cmd1_we(cmd1_we),
        .cmd1_addr(cmd1_addr), .cmd1_len(cmd1_len),
        .wd0_data(wd0_data), .wd0_ready(wd0_ready),
        .wd1_data(wd1_data), .wd1_ready(wd1_ready),
        .rd0_valid(rd0_valid), .rd1_valid(rd1_valid), .rd_data(rd_data),
        .done0(done0), .done1(done1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 ACLK = ~ACLK;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;

    always @(posedge ACLK) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {cmd0_ready, cmd1_ready, wd0_ready, wd1_ready, rd0_valid, rd1_valid,
                              done0, done1, mem_en, mem_we, busy, grant_id}, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_rdata"}, rd_data, 0);
    endtask

    initial begin
        // Reset with a pending request: ready must stay low.
        cmd0_valid = 1;
        tick();
        tick();
        #1;
        check_all_zero("reset");

        // Write burst: req0, len 7 at 0x00, data 1..8.
        ARESET = 0;
        cmd0_we = 1; cmd0_addr = 8'h00; cmd0_len = 3'd7; wd0_data = 1;
        #1;
        check("wr_ready0", cmd0_ready, 1);
        check("wr_ready1", cmd1_ready, 0);
        for (int b = 0; b < 8; b++) begin
            tick();
            cmd0_valid = 0; wd0_data = b + 1;
            #1;
            check("wr_ctl", {mem_en, mem_we, wd0_ready, wd1_ready, busy, grant_id}, 6'b111010);
            check("wr_addr", mem_addr, b);
            check("wr_wdata", mem_wdata, b + 1);
            check("wr_done0", done0, (b == 7));
        end
        tick();
        #1;
        check("wr_idle", {busy, done0, mem_en}, 0);
        check("wr_mem7", mem[7], 8);

        // Read back the same 8 words.
        cmd0_valid = 1; cmd0_we = 0;
        #1;
        check("rd_ready0", cmd0_ready, 1);
        for (int c = 1; c <= 9; c++) begin
            tick();
            cmd0_valid = 0;
            #1;
            check("rd_mem_en", {mem_en, mem_we}, {(c <= 8), 1'b0});
            if (c <= 8) check("rd_addr", mem_addr, c - 1);
            check("rd_valid", {rd0_valid, rd1_valid}, {(c >= 2), 1'b0});
            if (c >= 2) check("rd_data", rd_data, c - 1);
            check("rd_done0", done0, (c == 9));
        end
        tick();
        #1;
        check("rd_idle", {busy, rd0_valid, done0}, 0);

        // Ties after reset: req0, then req1 (round-robin) or req0 (fixed), then req0.
        ARESET = 1;
        tick();
        ARESET = 0;
        cmd0_valid = 1; cmd0_we = 1; cmd0_addr = 8'h10; cmd0_len = 0; wd0_data = 32'hAAAA;
        cmd1_valid = 1; cmd1_we = 1; cmd1_addr = 8'h20; cmd1_len = 0; wd1_data = 32'hBBBB;
        #1;
        check("tie1_ready", {cmd0_ready, cmd1_ready}, 2'b10);
        tick();
        #1;
        check("tie1_beat", {grant_id, done0, done1, cmd1_ready}, 4'b0100);
        check("tie1_addr", mem_addr, 8'h10);
`ifdef BCRYPT_ARB_FIXED_PRIO_EN
        exp_g = 1'b0;
`else
        exp_g = 1'b1;
`endif
        tick();
        #1;
        check("tie2_ready", {cmd0_ready, cmd1_ready}, {~exp_g, exp_g});
        tick();
        #1;
        check("tie2_beat", {grant_id, done0, done1, wd0_ready, wd1_ready}, {exp_g, ~exp_g, exp_g, ~exp_g, exp_g});
        check("tie2_wdata", mem_wdata, exp_g ? 32'hBBBB : 32'hAAAA);
        tick();
        #1;
        check("tie3_ready", {cmd0_ready, cmd1_ready}, 2'b10);
        tick();
        cmd0_valid = 0; cmd1_valid = 0;
        #1;
        check("tie3_beat", {grant_id, done0}, 2'b01);
        tick();

        // Address wrap: req1 reads len 3 at 0xFE.
        wrap_data[0] = 32'hC0DE00FE; wrap_data[1] = 32'hC0DE00FF;
        wrap_data[2] = 32'h1;        wrap_data[3] = 32'h2;
        cmd1_valid = 1; cmd1_we = 0; cmd1_addr = 8'hFE; cmd1_len = 3'd3;
        #1;
        check("wrap_ready", {cmd0_ready, cmd1_ready}, 2'b01);
        for (int c = 1; c <= 5; c++) begin
            tick();
            cmd1_valid = 0;
            #1;
            check("wrap_en", mem_en, (c <= 4));
            if (c <= 4) check("wrap_addr", mem_addr, 8'(8'hFE + c - 1));
            check("wrap_valid", {rd0_valid, rd1_valid}, {1'b0, (c >= 2)});
            if (c >= 2) check("wrap_data", rd_data, wrap_data[c - 2]);
            check("wrap_done1", done1, (c == 5));
        end
        tick();

        // Request raised mid-burst must wait for IDLE.
        cmd0_valid = 1; cmd0_we = 1; cmd0_addr = 8'h40; cmd0_len = 3'd7;
        tick();
        cmd0_valid = 0;
        for (int b = 0; b < 8; b++) begin
            wd0_data = 32'h500 + b;
            if (b == 2) begin
                cmd1_valid = 1; cmd1_we = 0; cmd1_addr = 8'h41; cmd1_len = 0;
            end
            #1;
            check("mid_ready1", cmd1_ready, 0);
            tick();
        end
        #1;
        check("mid_idle_ready", {busy, cmd0_ready, cmd1_ready}, 3'b001);
        tick();
        cmd1_valid = 0;
        #1;
        check("mid_rd_beat", {grant_id, mem_en, mem_we}, 3'b110);
        check("mid_rd_addr", mem_addr, 8'h41);
        tick();
        #1;
        check("mid_rd_drain", {rd1_valid, done1}, 2'b11);
        check("mid_rd_data", rd_data, 32'h501);
        tick();

        // Reset during beat 3 of an 8-beat write.
        cmd0_valid = 1; cmd0_we = 1; cmd0_addr = 8'h80; cmd0_len = 3'd7;
        tick();
        cmd0_valid = 0;
        for (int b = 0; b < 4; b++) begin
            wd0_data = 32'h100 + b;
            #1;
            check("rst_beat_addr", mem_addr, 8'h80 + b);
            if (b < 3) tick();
        end
        ARESET = 1;
        tick();
        #1;
        check_all_zero("rst_mid");
        ARESET = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            check("rst_after", {mem_en, done0, busy}, 0);
        end
        check("rst_mem83", mem[8'h83], 32'h103);
        check("rst_mem84", mem[8'h84], 32'hC0DE0084);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
